// File: rtl/booth_pkg.sv
// ============================================================
// booth_pkg : shared types and helpers for booth_seq_mult
// Rev 1.0
// ============================================================
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } sel_t;

  // Unsigned operands need one extra digit to consume the zero-extended MSBs.
  function automatic int num_digits(input int width, input logic is_signed);
    return is_signed ? width / 2 : width / 2 + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_digit_sel.sv
// ============================================================
// booth_digit_sel : radix-4 Booth digit to partial-product select
// Rev 1.0
// ============================================================
`default_nettype none

module booth_digit_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       digit,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+1:0] pp,
  output logic             comp
);

  sel_t sel;

  always_comb begin
    case (digit)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
  end

  // Negatives are one's complement here; comp supplies the +1 in the adder.
  always_comb begin
    pp   = '0;
    comp = 1'b0;
    case (sel)
      POS1: pp = m;
      POS2: pp = {m[WIDTH:0], 1'b0};
      NEG1: begin
        pp   = ~m;
        comp = 1'b1;
      end
      NEG2: begin
        pp   = ~{m[WIDTH:0], 1'b0};
        comp = 1'b1;
      end
      default: pp = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_seq_mult.sv
// ============================================================
// booth_seq_mult : iterative radix-4 Booth multiplier, one digit per clock
// Rev 1.0 -- optional early termination via BOOTH_EARLY_TERM_EN
// ============================================================
`default_nettype none

module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_signed
);

  localparam int M_W   = WIDTH + 2;
  localparam int HI_W  = WIDTH + 3;
  localparam int LO_W  = WIDTH + 2;
  localparam int ACC_W = HI_W + LO_W;
  localparam int Q_W   = WIDTH + 3;
  localparam int P_W   = 2 * WIDTH;
  localparam int SH_W  = $clog2(LO_W + 1);

  state_t             state_q, state_d;
  logic [M_W-1:0]     m_q, m_d;
  logic [Q_W-1:0]     q_q, q_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic               mode_q, mode_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [P_W-1:0]     out_p_q, out_p_d;
  logic               out_signed_q, out_signed_d;

  logic [M_W-1:0]     pp;
  logic               comp;
  logic [HI_W-1:0]    hi_sum;
  logic signed [ACC_W-1:0] sum;
  logic [SH_W-1:0]    shamt;
  logic [P_W-1:0]     prod;
  logic               last_digit;

  booth_digit_sel #(.WIDTH(WIDTH)) u_digit_sel (
    .digit (q_q[2:0]),
    .m     (m_q),
    .pp    (pp),
    .comp  (comp)
  );

  assign hi_sum = acc_q[ACC_W-1 -: HI_W] + {pp[M_W-1], pp} + HI_W'(comp);
  assign sum    = {hi_sum, acc_q[LO_W-1:0]};

  // Product sits 2*(digits retired) bits into the low half; realign in one shift.
  assign shamt  = SH_W'(LO_W) - SH_W'({cnt_q, 1'b0});
  assign prod   = P_W'(sum >>> shamt);

`ifdef BOOTH_EARLY_TERM_EN
  logic [Q_W-3:0] rest;
  assign rest       = q_q[Q_W-1:2];
  assign last_digit = (cnt_q == last_q) || (&rest) || (~|rest);
`else
  assign last_digit = (cnt_q == last_q);
`endif

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    q_d          = q_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    mode_d       = mode_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_p_d      = out_p_q;
    out_signed_d = out_signed_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = CALC;
          in_ready_d = 1'b0;
          m_d        = {(in_signed ? {2{in_a[WIDTH-1]}} : 2'b00), in_a};
          q_d        = {(in_signed ? {2{in_b[WIDTH-1]}} : 2'b00), in_b, 1'b0};
          acc_d      = '0;
          cnt_d      = '0;
          last_d     = CNT_W'(num_digits(WIDTH, in_signed) - 1);
          mode_d     = in_signed;
        end
      end
      CALC: begin
        acc_d = sum >>> 2;
        q_d   = $signed(q_q) >>> 2;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_digit) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_p_d      = prod;
          out_signed_d = mode_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      m_q          <= '0;
      q_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      last_q       <= '0;
      mode_q       <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_p_q      <= '0;
      out_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      q_q          <= q_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      mode_q       <= mode_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_p_q      <= out_p_d;
      out_signed_q <= out_signed_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_p      = out_p_q;
  assign out_signed = out_signed_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
// ============================================================
// tb_booth_seq_mult : directed self-checking bench for booth_seq_mult
// Rev 1.0
// ============================================================
`default_nettype none

module tb_booth_seq_mult;

`ifdef BOOTH_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        out_signed;

  int checks   = 0;
  int failures = 0;

  booth_seq_mult #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .out_signed (out_signed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents operands, returns #1 after the accepting edge with inputs scrambled.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_a      = ~a;
    in_b      = ~b;
    in_signed = ~s;
  endtask

  task automatic wait_done(input logic [31:0] exp_p, input logic exp_s, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_out_p"}, 64'(out_p), 64'(exp_p));
    chk({tag, "_out_signed"}, 64'(out_signed), 64'(exp_s));
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic [31:0] exp_p, input int exp_lat, input string tag);
    start_op(a, b, s, tag);
    wait_done(exp_p, s, exp_lat, tag);
    drain(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_out_signed", 64'(out_signed), 64'd0);

    run(16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB, ET ? 2 : 8, "s_m3x7");
    run(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 9, "u_ffffxffff");
    run(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, ET ? 1 : 8, "s_m1xm1");
    run(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 8, "s_minxmin");
    run(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 8, "s_minxmax");
    run(16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 9, "u_8000x8000");
    run(16'h1234, 16'h0005, 1'b0, 32'h0000_5B04, ET ? 2 : 9, "u_1234x5");
    run(16'h0005, 16'h0003, 1'b1, 32'h0000_000F, ET ? 2 : 8, "s_5x3");
    run(16'h0005, 16'hFFFF, 1'b1, 32'hFFFF_FFFB, ET ? 1 : 8, "s_5xm1");

    // Back-pressure: result must hold while a new request waits.
    start_op(16'h7FFF, 16'h7FFF, 1'b1, "hold");
    wait_done(32'h3FFF_0001, 1'b1, 8, "hold");
    in_a      = 16'hFFFF;
    in_b      = 16'h0002;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out_p", 64'(out_p), 64'h3FFF_0001);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_release_valid", 64'(out_valid), 64'd0);
    chk("hold_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 16'h0000;
    in_b     = 16'h0000;
    chk("hold_accepted", 64'(in_ready), 64'd0);
    wait_done(32'h0001_FFFE, 1'b0, ET ? 2 : 9, "after_hold");
    drain("after_hold");

    // Reset in the middle of the fourth CALC cycle.
    start_op(16'h1234, 16'h5678, 1'b1, "abort");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_p", 64'(out_p), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(16'h0002, 16'h0003, 1'b1, 32'h0000_0006, ET ? 2 : 8, "post_rst_2x3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Iterative radix-4 Booth multiplier. Retires one Booth digit per clock into a shifting accumulator.
- Parametrised successor to the combinational Booth partial-product cell:
  - generic WIDTH;
  - runtime signed/unsigned mode;
  - valid/ready handshake on both sides.
- Used in the multiplier subsystem where area matters more than throughput.
- Reuses the existing digit encoding (single/double/neg) for partial-product selection.

Parameters:
- WIDTH, 16, operand width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH/2+2), width of the digit counter; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier; Booth-recoded.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- out_p  output  2*WIDTH  product.
- out_signed  output  1  mode of the product being presented.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE;
  - in_ready = 1, out_valid = 0;
  - out_p = 0, out_signed = 0;
  - all internal registers cleared.
  - Reset mid-operation abandons the computation; no partial result is ever presented.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture the operands and go to CALC.
  - Extended multiplicand M: WIDTH+2 bits, sign-extended if in_signed, else zero-extended.
  - Multiplier shift register Q: {ext2(in_b), 1'b0}, WIDTH+3 bits.
  - Accumulator: cleared.
  - Digit count N = WIDTH/2 if signed, WIDTH/2+1 if unsigned; the extra digit absorbs the zero-extended MSBs.
- CALC, one digit per cycle:
  - Digit = Q[2:0], encoded as:
    - 000, 111 -> 0;
    - 001, 010 -> +M;
    - 011 -> +2M;
    - 100 -> -2M;
    - 101, 110 -> -M.
  - Negation is bitwise invert plus carry-in (the comp bit); there is no separate subtractor.
  - Upper accumulator bits += selected partial product, WIDTH+3-bit add.
  - Whole accumulator then arithmetic-shifts right by 2; Q shifts right by 2.
  - Counter increments. After digit N-1, go to DONE and load out_p with the low 2*WIDTH bits of the result.
  - All arithmetic is modulo 2^(2*WIDTH). No overflow is possible for the full-width product.
- DONE:
  - out_valid = 1; out_p and out_signed held stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
  - in_ready = 0 in CALC and DONE. There is no overlap of input acceptance with output presentation; in_valid arriving during DONE is simply held off by the producer.
- Latency:
  - Operand handshake at edge T; out_valid rises after edge T+N.
  - WIDTH=16: signed N=8, unsigned N=9.
  - Throughput: one product per N+2 cycles minimum.
- Input values are sampled only on the accepting edge. Later changes on in_a/in_b/in_signed are ignored.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined: at the start of each CALC cycle, if all unprocessed Q bits (including the overlap bit) are equal, every remaining digit is 0.
  - The block skips them: it performs the final correcting arithmetic shift in one step (shift by 2*(N-count)) and goes to DONE.
  - Latency becomes data-dependent, minimum 1 CALC cycle.
- Undefined: fixed N-cycle latency; the early-termination logic is absent.

Decomposition:
- Package booth_pkg holds:
  - state encoding (IDLE, CALC, DONE);
  - digit-select constants (ZERO, POS1, POS2, NEG1, NEG2);
  - a function computing N from WIDTH and mode.
- Sub-module booth_digit_sel:
  - inputs: 3-bit digit, M;
  - outputs: WIDTH+2-bit partial product, comp carry-in;
  - combinational, instantiated once.

Test Plan:
- Signed -3 x 7, WIDTH=16 -> out_p = 0xFFFFFFEB; out_valid exactly 8 cycles after acceptance edge; out_signed = 1.
- Unsigned 0xFFFF x 0xFFFF -> out_p = 0xFFFE0001 after 9 cycles. Signed 0xFFFF x 0xFFFF -> 0x00000001.
- Signed 0x8000 x 0x8000 -> 0x40000000. Signed 0x8000 x 0x7FFF -> 0xC0008000.
- Hold out_ready = 0 for 5 cycles in DONE -> out_p stable, in_ready = 0, new in_valid not accepted; accepted the cycle after out_ready handshake plus IDLE.
- Deassert rst_n during cycle 4 of CALC -> immediately out_valid = 0, in_ready = 1; next operation 2 x 3 -> 6, with no stale accumulator contribution.
- With BOOTH_EARLY_TERM_EN: signed 5 x 3 -> 15 with out_valid after 2 cycles. Signed 5 x -1 -> -5 after 1 cycle. Without the macro, both take 8 cycles.
